// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Initiator side of the ALU operand/result bus. Holds a small register file,
// accepts one command per handshake, drives registered operands and op to an
// external ALU, enables that ALU onto the shared tri-state result bus for
// exactly one cycle, captures the result and carry-out, writes the result back
// and updates the C/Z/N flags.
//
// Command sequence (one command in flight at a time):
//   IDLE  -> ISSUE : command accepted, operands snapshotted into alu_a/alu_b
//   ISSUE -> DRIVE : operands settle at the ALU, bus still released
//   DRIVE -> WB    : alu_e=1, alu_r/alu_cout captured at the end of the cycle
//   WB    -> IDLE  : register write-back, flag update, done pulse
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE and outside reset;
// the command fields only need to be stable while cmd_valid is high and
// cmd_ready is high. There is no back-pressure on done.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                000 add, 001 sub, 010 and, 011 or,
//                         100 neg, 101 shl, 110 shr, 111 nop
//   cmd_dst/srca/srcb     register addresses of the command
//   cmd_usec              1: alu_cin = flag_c, 0: alu_cin = 0
//   wr_en/wr_addr/wr_data host direct register write (any state)
//   rd_addr/rd_data       host combinational register read
//   alu_a/alu_b/alu_cin/alu_op  registered ALU inputs
//   alu_e                 ALU result-bus enable (DRIVE only)
//   alu_r/alu_cout        ALU result bus (Z while alu_e=0) and carry-out
//   busy                  high in any state other than IDLE
//   done                  one-cycle pulse in WB
//   flag_c/flag_z/flag_n  carry, zero, negative flags
//   dbg_state             current FSM state (IDLE=0 ISSUE=1 DRIVE=2 WB=3)
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_AW     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command interface
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [REG_AW-1:0]     cmd_dst,
    input  logic [REG_AW-1:0]     cmd_srca,
    input  logic [REG_AW-1:0]     cmd_srcb,
    input  logic                  cmd_usec,
    // host register access
    input  logic                  wr_en,
    input  logic [REG_AW-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [REG_AW-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    // ALU interface
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic                  alu_cin,
    output logic [2:0]            alu_op,
    output logic                  alu_e,
    input  logic [DATA_WIDTH-1:0] alu_r,
    input  logic                  alu_cout,
    // status
    output logic                  busy,
    output logic                  done,
    output logic                  flag_c,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic [1:0]            dbg_state
);

    localparam int NREGS = 1 << REG_AW;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRIVE = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [DATA_WIDTH-1:0] r_regs [NREGS];

    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic                  r_alu_cin;
    logic [2:0]            r_alu_op;
    logic [REG_AW-1:0]     r_dst;

    // Result and carry captured from the bus at the end of DRIVE.
    logic [DATA_WIDTH-1:0] r_res;
    logic                  r_cout;

    logic                  r_flag_c;
    logic                  r_flag_z;
    logic                  r_flag_n;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_in_drive;
    logic                  w_in_wb;
    logic                  w_wb_en;
    logic                  w_carry_new;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and state decodes
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_in_drive   = 1'b0;
        w_in_wb      = 1'b0;
        busy         = 1'b1;

        case (r_state)
            ST_IDLE: begin
                busy    = 1'b0;
                // Gating with rst_n keeps the initiator from advertising
                // readiness while it is being held in reset.
                w_ready = rst_n;
                if (cmd_valid && rst_n) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_DRIVE;
            end
            ST_DRIVE: begin
                w_in_drive   = 1'b1;
                w_next_state = ST_WB;
            end
            ST_WB: begin
                w_in_wb      = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_accept  = cmd_valid & w_ready;

    // nop still walks the full sequence and pulses done, but writes nothing.
    assign w_wb_en   = w_in_wb & (r_alu_op != OP_NOP);

    // Only the arithmetic ops report a carry; logic and shift ops clear C.
    assign w_carry_new = ((r_alu_op == OP_ADD) || (r_alu_op == OP_SUB)) ? r_cout : 1'b0;

    // -------------------------------------------------------------------------
    // Register file. The write-back assignment comes after the host write so
    // that it wins when both target the same register in the WB cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                r_regs[wr_addr] <= wr_data;
            end
            if (w_wb_en) begin
                r_regs[r_dst] <= r_res;
            end
        end
    end

    assign rd_data = r_regs[rd_addr];

    // -------------------------------------------------------------------------
    // Operand snapshot, bus capture and flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_cin <= 1'b0;
            r_alu_op  <= 3'b000;
            r_dst     <= '0;
            r_res     <= '0;
            r_cout    <= 1'b0;
            r_flag_c  <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_n  <= 1'b0;
        end else begin
            // Operands are copied out of the file at accept, so later host
            // writes cannot disturb the command already in flight.
            if (w_accept) begin
                r_alu_a   <= r_regs[cmd_srca];
                r_alu_b   <= r_regs[cmd_srcb];
                r_alu_cin <= cmd_usec & r_flag_c;
                r_alu_op  <= cmd_op;
                r_dst     <= cmd_dst;
            end

            // The bus is only looked at while this block drives alu_e, so a
            // floating bus in other states never reaches r_res.
            if (w_in_drive) begin
                r_res  <= alu_r;
                r_cout <= alu_cout;
            end

            if (w_wb_en) begin
                r_flag_c <= w_carry_new;
                r_flag_z <= (r_res == '0);
                r_flag_n <= r_res[DATA_WIDTH-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmd_ready = w_ready;
    assign alu_e     = w_in_drive;
    assign done      = w_in_wb;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_cin   = r_alu_cin;
    assign alu_op    = r_alu_op;
    assign flag_c    = r_flag_c;
    assign flag_z    = r_flag_z;
    assign flag_n    = r_flag_n;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
module tb_alu_sequencer;

    // ---------------------------------------------------------------- signals
    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_srca;
    logic [1:0] cmd_srcb;
    logic       cmd_usec;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [2:0] alu_op;
    logic       alu_e;
    wire  [7:0] alu_r;
    logic       alu_cout;
    logic       busy;
    logic       done;
    logic       flag_c;
    logic       flag_z;
    logic       flag_n;
    logic [1:0] dbg_state;

    alu_sequencer #(.DATA_WIDTH(8), .REG_AW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_usec  (cmd_usec),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_op    (alu_op),
        .alu_e     (alu_e),
        .alu_r     (alu_r),
        .alu_cout  (alu_cout),
        .busy      (busy),
        .done      (done),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------ clock and counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ----------------------------------------------------------- ALU model
    // Sub reports borrow as carry; nop drives a marker so a wrong write-back
    // would be visible.
    logic [7:0] alu_res_m;
    logic       alu_c_m;
    logic [8:0] alu_wide;
    always_comb begin
        alu_res_m = 8'h00;
        alu_c_m   = 1'b0;
        alu_wide  = 9'h000;
        case (alu_op)
            3'd0: begin
                alu_wide  = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
                alu_res_m = alu_wide[7:0];
                alu_c_m   = alu_wide[8];
            end
            3'd1: begin
                alu_wide  = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
                alu_res_m = alu_wide[7:0];
                alu_c_m   = alu_wide[8];
            end
            3'd2: alu_res_m = alu_a & alu_b;
            3'd3: alu_res_m = alu_a | alu_b;
            3'd4: begin alu_res_m = ~alu_a + 8'd1; alu_c_m = |alu_a; end
            3'd5: begin alu_res_m = {alu_a[6:0], 1'b0}; alu_c_m = alu_a[7]; end
            3'd6: begin alu_res_m = {1'b0, alu_a[7:1]}; alu_c_m = alu_a[0]; end
            default: begin alu_res_m = 8'h5A; alu_c_m = 1'b1; end
        endcase
    end
    assign alu_r    = alu_e ? alu_res_m : 8'bz;
    assign alu_cout = alu_c_m;

    // ------------------------------------------------------------ scoreboard
    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [1:0] dst;
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       n;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    exp_t pend;
    bit   pend_v     = 0;
    bit   init_chk   = 0;
    bit   abort_mode = 0;
    int   total      = 0;
    int   bad        = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin
        rd_addr = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_v = 0;
            end else begin
                if (!init_chk) begin
                    for (int i = 0; i < 4; i++) begin
                        rd_addr = 2'(i);
                        #1;
                        chk($sformatf("reset_reg%0d", i), 32'(rd_data), 32'h0);
                    end
                    init_chk = 1;
                end
                // Results are visible the cycle after the WB cycle.
                if (pend_v) begin
                    chk("flag_c", 32'(flag_c), 32'(pend.c));
                    chk("flag_z", 32'(flag_z), 32'(pend.z));
                    chk("flag_n", 32'(flag_n), 32'(pend.n));
                    rd_addr = pend.dst;
                    #1;
                    chk($sformatf("reg%0d", pend.dst), 32'(rd_data), 32'(pend.r));
                    pend_v = 0;
                end
                chk("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
                if (alu_e && !abort_mode) begin
                    if (exp_q.size() == 0) begin
                        flag_fail("alu_e_without_command");
                    end else begin
                        chk("alu_a",   32'(alu_a),   32'(exp_q[0].a));
                        chk("alu_b",   32'(alu_b),   32'(exp_q[0].b));
                        chk("alu_cin", 32'(alu_cin), 32'(exp_q[0].cin));
                        chk("alu_op",  32'(alu_op),  32'(exp_q[0].op));
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        flag_fail("done_without_command");
                    end else begin
                        pend   = exp_q.pop_front();
                        // cyc counts edges; the done cycle ends at accept edge + 3.
                        chk("done_latency", 32'(cyc - acc_q.pop_front() + 1), 32'd3);
                        pend_v = 1;
                    end
                end
            end
        end
    end

    // ----------------------------------------------------------- driver tasks
    int last_acc = 0;

    task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic u, input logic [7:0] ea,
                         input logic [7:0] eb, input logic ecin, input logic [7:0] er,
                         input logic ec, input logic ez, input logic en, input bit expect_done);
        exp_t e;
        bit   rdy;
        bit   ok;
        e = '{op: op, a: ea, b: eb, cin: ecin, dst: dst, r: er, c: ec, z: ez, n: en};
        if (expect_done) exp_q.push_back(e);
        @(negedge clk);
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_srca  = sa;
        cmd_srcb  = sb;
        cmd_usec  = u;
        cmd_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        #1;
        if (!ok) flag_fail("accept_timeout");
        last_acc = cyc;
        if (expect_done && ok) acc_q.push_back(cyc);
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0 && !pend_v) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) flag_fail("drain_timeout");
        @(negedge clk);
    endtask

    // -------------------------------------------------------------- stimulus
    int acc_prev;

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_dst   = 2'd0;
        cmd_srca  = 2'd0;
        cmd_srcb  = 2'd0;
        cmd_usec  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 2'd0;
        wr_data   = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_alu_e", 32'(alu_e),     32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
        chk("rst_alu_ab", 32'({alu_a, alu_b, alu_cin, alu_op}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);
        @(negedge clk);

        // ADD with carry out
        host_wr(2'd0, 8'hF0);
        host_wr(2'd1, 8'h20);
        issue(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1);
        wait_drain();

        // SUB to zero, then carry chain through usec
        host_wr(2'd0, 8'h05);
        host_wr(2'd1, 8'h05);
        issue(3'd1, 2'd3, 2'd0, 2'd1, 1'b0, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        wait_drain();
        issue(3'd0, 2'd2, 2'd0, 2'd1, 1'b1, 8'h05, 8'h05, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b0, 1);
        wait_drain();
        issue(3'd1, 2'd3, 2'd0, 2'd2, 1'b0, 8'h05, 8'h0A, 1'b0, 8'hFB, 1'b1, 1'b0, 1'b1, 1);
        wait_drain();
        issue(3'd0, 2'd3, 2'd0, 2'd1, 1'b1, 8'h05, 8'h05, 1'b1, 8'h0B, 1'b0, 1'b0, 1'b0, 1);
        wait_drain();

        // Logic ops
        host_wr(2'd0, 8'h0F);
        host_wr(2'd1, 8'hF0);
        issue(3'd2, 2'd2, 2'd0, 2'd1, 1'b0, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        wait_drain();
        issue(3'd3, 2'd1, 2'd0, 2'd1, 1'b0, 8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1);
        wait_drain();

        // Back-to-back with cmd_valid held: neg, shl, shr
        issue(3'd4, 2'd3, 2'd0, 2'd0, 1'b0, 8'h0F, 8'h0F, 1'b0, 8'hF1, 1'b0, 1'b0, 1'b1, 1);
        acc_prev = last_acc;
        issue(3'd5, 2'd3, 2'd1, 2'd1, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1, 1);
        chk("b2b_spacing_1", 32'(last_acc - acc_prev), 32'd4);
        acc_prev = last_acc;
        issue(3'd6, 2'd2, 2'd0, 2'd0, 1'b0, 8'h0F, 8'h0F, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1);
        chk("b2b_spacing_2", 32'(last_acc - acc_prev), 32'd4);
        wait_drain();

        // Collisions: write srca during ISSUE, write dst during WB
        host_wr(2'd0, 8'h10);
        host_wr(2'd1, 8'h01);
        issue(3'd0, 2'd2, 2'd0, 2'd1, 1'b1, 8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("state_issue", 32'(dbg_state), 32'd1);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h99;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        chk("state_wb", 32'(dbg_state), 32'd3);
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hAA;
        @(negedge clk);
        wr_en = 1'b0;
        wait_drain();
        // r0 must now hold the host value written during ISSUE
        issue(3'd3, 2'd3, 2'd0, 2'd0, 1'b0, 8'h99, 8'h99, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 1);
        wait_drain();

        // Reset during DRIVE abandons the command
        host_wr(2'd0, 8'h33);
        host_wr(2'd1, 8'h44);
        abort_mode = 1;
        issue(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_drive", 32'(alu_e), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_alu_e",  32'(alu_e), 32'd0);
        chk("abort_busy",   32'(busy),  32'd0);
        chk("abort_ready",  32'(cmd_ready), 32'd0);
        chk("abort_flags",  32'({flag_c, flag_z, flag_n}), 32'd0);
        chk("abort_alu_a",  32'(alu_a), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) flag_fail("done_after_abort");
        end
        chk("abort_no_done_state", 32'(dbg_state), 32'd0);
        abort_mode = 0;
        // dst of the abandoned command must still read zero
        issue(3'd3, 2'd3, 2'd2, 2'd2, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        wait_drain();

        // nop: done pulses, no write-back, flags unchanged
        host_wr(2'd0, 8'h80);
        host_wr(2'd1, 8'h80);
        issue(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1);
        wait_drain();
        issue(3'd7, 2'd0, 2'd0, 2'd1, 1'b1, 8'h80, 8'h80, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
